// File: rtl/clk_div_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_div_gen_pkg
// Brief    : Shared state encodings and default widths for the clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_gen_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/clk_div_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_div_gen_if
// Brief    : Ratio-reprogramming valid/ready channel of the clock divider.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_gen_if
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_div, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_div, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/clk_div_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Brief    : Programmable divider: tick pulse every N cycles, 50% divided
//            clock and tick counter; ratio changes land on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 4,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    clk_div_gen_if.slave          cfg,
    output logic                  tick,
    output logic                  div_clk,
    output logic [CNT_W-1:0]      tick_cnt
);

    localparam logic [DIV_W-1:0] c_default_div =
        (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

    function automatic logic [DIV_W-1:0] max1(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    state_e             state_q,    state_d;
    logic [DIV_W-1:0]   cnt_q,      cnt_d;
    logic [DIV_W-1:0]   ratio_q,    ratio_d;
    logic [DIV_W-1:0]   pending_q,  pending_d;
    logic               tick_q,     tick_d;
    logic               div_clk_q,  div_clk_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               cfg_ready_q, cfg_ready_d;

    logic [DIV_W-1:0]   w_n;
    logic               w_terminal;
    logic               w_hs;
    logic               w_has_pending;
    logic               w_apply;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ratio_q     <= c_default_div;
            pending_q   <= '0;
            tick_q      <= 1'b0;
            div_clk_q   <= 1'b0;
            tick_cnt_q  <= '0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            pending_q   <= pending_d;
            tick_q      <= tick_d;
            div_clk_q   <= div_clk_d;
            tick_cnt_q  <= tick_cnt_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // A handshake taken while idle leaves the state in IDLE with cfg_ready low,
    // so a held ratio is recognised from either the state or the ready flag.
    always_comb begin
        w_n           = max1(ratio_q);
        w_terminal    = (cnt_q == w_n - DIV_W'(1));
        w_hs          = cfg.cfg_valid & cfg_ready_q;
        w_has_pending = (state_q == ST_PEND) | ~cfg_ready_q;
        w_apply       = w_has_pending & (~en | w_terminal);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        pending_d   = pending_q;
        tick_d      = 1'b0;
        div_clk_d   = div_clk_q;
        tick_cnt_d  = tick_cnt_q;
        cfg_ready_d = cfg_ready_q;

        if (en) begin
            if (w_terminal) begin
                cnt_d      = '0;
                tick_d     = 1'b1;
                div_clk_d  = ~div_clk_q;
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end else begin
                cnt_d      = cnt_q + DIV_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (w_apply) begin
            ratio_d     = pending_q;
            cfg_ready_d = 1'b1;
        end

        // Never coincides with w_apply: a handshake needs cfg_ready high.
        if (w_hs) begin
            pending_d   = max1(cfg.cfg_div);
            cfg_ready_d = 1'b0;
        end

        if (!en) begin
            state_d = ST_IDLE;
        end else if (!cfg_ready_d) begin
            state_d = ST_PEND;
        end else begin
            state_d = ST_RUN;
        end
    end

    assign tick          = tick_q;
    assign div_clk       = div_clk_q;
    assign tick_cnt      = tick_cnt_q;
    assign cfg.cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Brief    : Self-checking bench for clk_div_gen with an edge-scheduling model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    localparam int DIV_W = 16;
    localparam int CNT_W = 32;
    localparam int DEF_N = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic             tick;
    logic             div_clk;
    logic [CNT_W-1:0] tick_cnt;

    int n_cmp;
    int n_err;

    clk_div_gen_if #(.DIV_W(DIV_W)) cfg_if ();

    clk_div_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_N),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg      (cfg_if.slave),
        .tick     (tick),
        .div_clk  (div_clk),
        .tick_cnt (tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: tracks the absolute edge number of the next tick
    // rather than a phase counter.
    int               ed;
    int               m_next;
    bit               m_running;
    int               m_n;
    bit               m_pend;
    int               m_pend_val;
    bit               m_tick;
    bit               m_div;
    logic [CNT_W-1:0] m_tcnt;

    task automatic model_edge(input bit r, input bit e, input bit v, input int d);
        bit hs;
        if (r) begin
            m_n = DEF_N; m_pend = 0; m_running = 0;
            m_tick = 0; m_div = 0; m_tcnt = '0;
        end else begin
            hs = v && !m_pend;
            if (e) begin
                if (!m_running) begin
                    m_running = 1;
                    m_next    = ed + m_n - 1;
                end
                m_tick = (ed == m_next);
                if (m_tick) begin
                    m_div  = ~m_div;
                    m_tcnt = m_tcnt + 1;
                    if (m_pend) begin
                        m_n    = m_pend_val;
                        m_pend = 0;
                    end
                    m_next = ed + m_n;
                end
            end else begin
                m_running = 0;
                m_tick    = 0;
                if (m_pend) begin
                    m_n    = m_pend_val;
                    m_pend = 0;
                end
            end
            if (hs) begin
                m_pend     = 1;
                m_pend_val = (d == 0) ? 1 : d;
            end
        end
        ed++;
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int d);
        rst              = r;
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_div   = DIV_W'(d);
        @(posedge clk);
        model_edge(r, e, v, d);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_cmp++; if (div_clk !== 1'b0) begin n_err++; $display("FAIL reset_div_clk: got %b want 0", div_clk); end
        n_cmp++; if (tick_cnt !== '0) begin n_err++; $display("FAIL reset_tick_cnt: got %0d want 0", tick_cnt); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_steady_run();
        logic exp_div;
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0);
            exp_div = (((i + 1) / 4) % 2) == 1;
            n_cmp++; if (tick !== (i % 4 == 3)) begin n_err++; $display("FAIL run_tick edge %0d: got %b want %b", i, tick, (i % 4 == 3)); end
            n_cmp++; if (div_clk !== exp_div) begin n_err++; $display("FAIL run_div_clk edge %0d: got %b want %b", i, div_clk, exp_div); end
        end
        n_cmp++; if (tick_cnt !== 32'd3) begin n_err++; $display("FAIL run_tick_cnt: got %0d want 3", tick_cnt); end
    endtask

    task automatic test_ratio_change();
        logic exp_tick, exp_rdy;
        step(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, (i == 1), 6);
            exp_tick = (i == 3) || (i == 9) || (i == 15);
            exp_rdy  = !((i == 1) || (i == 2));
            n_cmp++; if (tick !== exp_tick) begin n_err++; $display("FAIL chg_tick edge %0d: got %b want %b", i, tick, exp_tick); end
            n_cmp++; if (cfg_if.cfg_ready !== exp_rdy) begin n_err++; $display("FAIL chg_cfg_ready edge %0d: got %b want %b", i, cfg_if.cfg_ready, exp_rdy); end
        end
        n_cmp++; if (tick_cnt !== 32'd3) begin n_err++; $display("FAIL chg_tick_cnt: got %0d want 3", tick_cnt); end
    endtask

    task automatic test_terminal_handshake();
        logic exp_tick, exp_rdy;
        step(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            // Edge 4 offers a second ratio while one is pending; it must be dropped.
            step(0, 1, (i == 3) || (i == 4), (i == 3) ? 2 : 5);
            exp_tick = (i == 3) || (i == 7) || (i == 9) || (i == 11) || (i == 13);
            exp_rdy  = !(i >= 3 && i < 7);
            n_cmp++; if (tick !== exp_tick) begin n_err++; $display("FAIL term_tick edge %0d: got %b want %b", i, tick, exp_tick); end
            n_cmp++; if (cfg_if.cfg_ready !== exp_rdy) begin n_err++; $display("FAIL term_cfg_ready edge %0d: got %b want %b", i, cfg_if.cfg_ready, exp_rdy); end
        end
    endtask

    task automatic test_ratio_one();
        logic exp_div;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL one_ready_held: got %b want 0", cfg_if.cfg_ready); end
        step(0, 0, 0, 0);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL one_ready_applied: got %b want 1", cfg_if.cfg_ready); end
        exp_div = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            exp_div = ~exp_div;
            n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL one_tick edge %0d: got %b want 1", i, tick); end
            n_cmp++; if (div_clk !== exp_div) begin n_err++; $display("FAIL one_div_clk edge %0d: got %b want %b", i, div_clk, exp_div); end
        end
        n_cmp++; if (tick_cnt !== 32'd6) begin n_err++; $display("FAIL one_tick_cnt: got %0d want 6", tick_cnt); end
    endtask

    task automatic test_en_drop_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 8);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL drop_cfg_ready: got %b want 1", cfg_if.cfg_ready); end
        n_cmp++; if (div_clk !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL drop_outputs: got div_clk=%b tick=%b want 0/0", div_clk, tick); end
        for (int j = 0; j < 9; j++) begin
            step(0, 1, 0, 0);
            n_cmp++; if (tick !== (j == 7)) begin n_err++; $display("FAIL drop_tick edge %0d: got %b want %b", j, tick, (j == 7)); end
        end
        step(0, 1, 1, 3);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL drop_pend_ready: got %b want 0", cfg_if.cfg_ready); end
        step(1, 1, 0, 0);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || tick_cnt !== '0 || div_clk !== 1'b0) begin
            n_err++; $display("FAIL rst_in_pend: got ready=%b cnt=%0d div=%b want 1/0/0", cfg_if.cfg_ready, tick_cnt, div_clk);
        end
        for (int j = 0; j < 8; j++) begin
            step(0, 1, 0, 0);
            n_cmp++; if (tick !== (j % 4 == 3)) begin n_err++; $display("FAIL rst_ratio_tick edge %0d: got %b want %b", j, tick, (j % 4 == 3)); end
        end
    endtask

    task automatic test_random();
        bit r, e, v;
        int d;
        step(1, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(199) == 0);
            e = ($urandom_range(99) < 85);
            v = ($urandom_range(99) < 15);
            d = int'($urandom_range(7));
            step(r, e, v, d);
            n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL rnd_tick step %0d: got %b want %b", i, tick, m_tick); end
            n_cmp++; if (div_clk !== m_div) begin n_err++; $display("FAIL rnd_div_clk step %0d: got %b want %b", i, div_clk, m_div); end
            n_cmp++; if (tick_cnt !== m_tcnt) begin n_err++; $display("FAIL rnd_tick_cnt step %0d: got %0d want %0d", i, tick_cnt, m_tcnt); end
            n_cmp++; if (cfg_if.cfg_ready !== !m_pend) begin n_err++; $display("FAIL rnd_cfg_ready step %0d: got %b want %b", i, cfg_if.cfg_ready, !m_pend); end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ed = 0;
        m_next = 0; m_running = 0; m_n = DEF_N; m_pend = 0; m_pend_val = 1;
        m_tick = 0; m_div = 0; m_tcnt = '0;
        rst = 1'b1; en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;

        test_reset();
        test_steady_run();
        test_ratio_change();
        test_terminal_handshake();
        test_ratio_one();
        test_en_drop_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
